dcache_mem_responder: RTL and testbench

DCACHE_MEM_RESPONDER -- requirements
Module: dcache_mem_responder

---
 rtl/dcache_mem_responder.sv | 152 +++++++++++++++
 tb/tb_dcache_mem_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dcache_mem_responder.sv
// Line-burst memory model answering data-cache refills (read bursts after a
// fixed latency) and write-backs (initiator-paced write beats).
module dcache_mem_responder #(
  parameter int LINE_WORDS = 8,
  parameter int MEM_WORDS  = 4096,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_req,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        wlast,
  output logic        mem_addr_ok,
  output logic        mem_data_ok,
  output logic [31:0] mem_rdata,
  output logic        busy,
  output logic        err
);

  localparam int CW = $clog2(LINE_WORDS);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [CW-1:0] LAST     = CW'(LINE_WORDS - 1);
  localparam logic [3:0]    LAT_INIT = 4'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RLAT  = 2'd1,
    S_RDATA = 2'd2,
    S_WDATA = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    lat_q, lat_d;
  logic [AW-1:0] base_q, base_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rd_ok_q, rd_ok_d;
  logic          err_q, err_d;

  logic [31:0]   mem_q [MEM_WORDS];

  logic          wr_beat_s;
  logic [AW-1:0] wr_idx_s;
  logic [AW-1:0] rd_idx_s;
  logic          unused_addr_s;

  // Base is line aligned, so adding the beat count never carries out of the line.
  assign wr_beat_s     = (state_q == S_WDATA) & mem_req;
  assign wr_idx_s      = base_q + AW'(cnt_q);
  assign rd_idx_s      = wr_idx_s + ((state_q == S_RDATA) ? AW'(1) : AW'(0));
  assign unused_addr_s = ^{mem_addr[31:AW+2], mem_addr[CW+1:0]};

  assign mem_addr_ok = resetn & (state_q == S_IDLE) & mem_req;
  assign mem_data_ok = rd_ok_q | wr_beat_s;
  assign mem_rdata   = rdata_q;
  assign busy        = (state_q != S_IDLE);
  assign err         = err_q;

  // Next-state logic: the read output register is preloaded one cycle ahead of each beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    base_d  = base_q;
    rdata_d = rdata_q;
    rd_ok_d = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          base_d = {mem_addr[AW+1:CW+2], {CW{1'b0}}};
          cnt_d  = {CW{1'b0}};
          if (mem_wr) begin
            state_d = S_WDATA;
          end else begin
            state_d = S_RLAT;
            lat_d   = LAT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RLAT: begin
        if (lat_q == 4'd0) begin
          state_d = S_RDATA;
          rdata_d = mem_q[rd_idx_s];
          rd_ok_d = 1'b1;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      S_RDATA: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
        end else begin
          rdata_d = mem_q[rd_idx_s];
          rd_ok_d = 1'b1;
        end
      end
      S_WDATA: begin
        if (mem_req) begin
          cnt_d = cnt_q + CW'(1);
          if (wlast != (cnt_q == LAST)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (cnt_q == LAST) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WDATA;
          end
        end else begin
          state_d = S_WDATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      lat_q   <= 4'd0;
      base_q  <= {AW{1'b0}};
      rdata_q <= 32'd0;
      rd_ok_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      base_q  <= base_d;
      rdata_q <= rdata_d;
      rd_ok_q <= rd_ok_d;
      err_q   <= err_d;
    end
  end

  // Backing store keeps its content across reset.
  always_ff @(posedge clk) begin
    if (wr_beat_s) begin
      mem_q[wr_idx_s] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Directed bench for dcache_mem_responder with default parameters
// (8-word lines, 4096-word store, read latency 2).
module tb_dcache_mem_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        wlast;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;

  dcache_mem_responder dut (
    .clk         (clk),
    .resetn      (resetn),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .wlast       (wlast),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Write burst of d0+beat; wlast only on beat wl_beat; gap bit c drops mem_req in WDATA cycle c.
  task automatic wr_burst(input logic [31:0] addr, input logic [31:0] d0, input int wl_beat,
                          input logic [15:0] gap, input int exp_cycles, input string tag);
    int beat;
    int c;
    @(negedge clk);
    mem_req = 1'b1; mem_wr = 1'b1; mem_addr = addr; wlast = 1'b0;
    #1;
    chk1({tag, "/addr_ok"}, mem_addr_ok, 1'b1);
    chk1({tag, "/idle_busy"}, busy, 1'b0);
    beat = 0;
    c = 0;
    while (beat < 8 && c < 20) begin
      @(negedge clk);
      mem_req   = ~gap[c];
      mem_wr    = 1'b0;
      mem_wdata = d0 + 32'(beat);
      wlast     = (beat == wl_beat);
      #1;
      chk1({tag, "/data_ok"}, mem_data_ok, ~gap[c]);
      chk1({tag, "/busy"}, busy, 1'b1);
      chk1({tag, "/no_addr_ok"}, mem_addr_ok, 1'b0);
      if (~gap[c]) beat++;
      c++;
    end
    chk({tag, "/cycles"}, 32'(c), 32'(exp_cycles));
    @(negedge clk);
    mem_req = 1'b0; wlast = 1'b0;
    #1;
    chk1({tag, "/done_busy"}, busy, 1'b0);
    chk1({tag, "/done_data_ok"}, mem_data_ok, 1'b0);
  endtask

  // Refill; beat k expected as (k<4 ? lo0 : hi0) + k.
  task automatic rd_burst(input logic [31:0] addr, input logic [31:0] lo0, input logic [31:0] hi0,
                          input string tag);
    @(negedge clk);
    mem_req = 1'b1; mem_wr = 1'b0; mem_addr = addr; wlast = 1'b0;
    #1;
    chk1({tag, "/addr_ok"}, mem_addr_ok, 1'b1);
    chk1({tag, "/acc_data_ok"}, mem_data_ok, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      mem_req = 1'b0;
      #1;
      if (c < 3) begin
        chk1({tag, "/lat_data_ok"}, mem_data_ok, 1'b0);
        chk1({tag, "/lat_busy"}, busy, 1'b1);
      end else if (c <= 10) begin
        chk1({tag, "/beat_data_ok"}, mem_data_ok, 1'b1);
        chk({tag, "/rdata"}, mem_rdata, (((c - 3) < 4) ? lo0 : hi0) + 32'(c - 3));
        chk1({tag, "/beat_busy"}, busy, 1'b1);
      end else begin
        chk1({tag, "/end_busy"}, busy, 1'b0);
        chk1({tag, "/end_data_ok"}, mem_data_ok, 1'b0);
        chk({tag, "/rdata_hold"}, mem_rdata, hi0 + 32'd7);
      end
    end
  endtask

  initial begin
    resetn = 1'b0; mem_req = 1'b1; mem_wr = 1'b0; mem_addr = 32'd0;
    mem_wdata = 32'd0; wlast = 1'b0;
    #12;
    chk1("rst/addr_ok", mem_addr_ok, 1'b0);
    chk1("rst/data_ok", mem_data_ok, 1'b0);
    chk("rst/rdata", mem_rdata, 32'd0);
    chk1("rst/busy", busy, 1'b0);
    chk1("rst/err", err, 1'b0);
    @(negedge clk);
    mem_req = 1'b0;
    resetn  = 1'b1;

    // Basic write-back then refill of the same line from a mid-line address.
    wr_burst(32'h0000_0100, 32'hA0, 7, 16'h0000, 8, "w31");
    chk1("w31/err", err, 1'b0);
    rd_burst(32'h0000_0114, 32'hA0, 32'hA0, "r32");

    // Initiator stalls in WDATA cycles 2 and 5.
    wr_burst(32'h0000_0200, 32'hB0, 7, 16'h0024, 10, "w33");
    chk1("w33/err", err, 1'b0);
    rd_burst(32'h0000_0200, 32'hB0, 32'hB0, "r33");

    // Misplaced wlast makes err sticky.
    wr_burst(32'h0000_0300, 32'hC0, 3, 16'h0000, 8, "w34");
    chk1("w34/err_set", err, 1'b1);
    wr_burst(32'h0000_0340, 32'hC8, 7, 16'h0000, 8, "w34b");
    chk1("w34b/err_sticky", err, 1'b1);
    rd_burst(32'h0000_0300, 32'hC0, 32'hC0, "r34");
    chk1("r34/err_sticky", err, 1'b1);

    // Top-of-memory line and address wrap-around.
    wr_burst(32'h0000_3FE0, 32'hD0, 7, 16'h0000, 8, "w35");
    rd_burst(32'h0000_3FF0, 32'hD0, 32'hD0, "r35");
    wr_burst(32'h0001_0000, 32'hE0, 7, 16'h0000, 8, "w35w");
    rd_burst(32'h0000_0000, 32'hE0, 32'hE0, "r35w");

    // Reset during write beat 4.
    wr_burst(32'h0000_0400, 32'hF0, 7, 16'h0000, 8, "w36pre");
    @(negedge clk);
    mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 32'h0000_0400; wlast = 1'b0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      mem_wr = 1'b0;
      mem_wdata = 32'h50 + 32'(b);
      #1;
      chk1("w36/data_ok", mem_data_ok, 1'b1);
    end
    @(negedge clk);
    mem_wdata = 32'h54;
    resetn = 1'b0;
    #1;
    chk1("w36/rst_busy", busy, 1'b0);
    chk1("w36/rst_data_ok", mem_data_ok, 1'b0);
    chk1("w36/rst_addr_ok", mem_addr_ok, 1'b0);
    chk("w36/rst_rdata", mem_rdata, 32'd0);
    chk1("w36/rst_err", err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    mem_req = 1'b0;
    resetn = 1'b1;
    rd_burst(32'h0000_0400, 32'h50, 32'hF0, "r36");
    chk1("r36/err", err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
